bisection_sequencer: RTL
========================

// Module: bisection_sequencer
// PURPOSE
//  Runs one bias-current search: drives the bisection core one step per iteration, loads its
//  i_ref into the reference DAC, waits for settling, requests a Q measurement and feeds it back.
//  Sits between the top-level control FSM (start/abort/status) and bisection core + DAC + Q meter.
//  Ends the search on |Q error| <= TOL, iteration limit, measurement timeout or abort.
// PARAMETERS
//  WIDTH          10   bus width of Q and i_ref codes
//  TOL            1    convergence threshold on |measured_q - desired_q|
//  MAX_ITER       12   max iterations (measurements) per search, >=1
//  SETTLE_CYCLES  16   clk cycles between dac_load and meas_req, >=1
//  CORE_LAT       2    clk cycles after core_step before core_i_ref is valid, >=1
//  TIMEOUT_CYCLES 255  max clk cycles meas_req may wait for meas_valid
// PORTS
//  clk             in   1       clock
//  rst             in   1       sync active-high reset
//  start           in   1       1-cycle pulse, begins search; ignored unless IDLE
//  abort           in   1       level; forces return to IDLE from any state
//  desired_q       in   WIDTH   target Q, sampled on accepted start
//  core_i_ref      in   WIDTH   midpoint from bisection core
//  core_rst        out  1       1-cycle reset pulse to core at search start
//  core_ready      out  1       1-cycle step strobe to core
//  core_measured_q out  WIDTH   last measured Q, held to core
//  dac_code        out  WIDTH   reference DAC code
//  dac_load        out  1       1-cycle DAC load strobe
//  meas_req        out  1       held high until meas_valid
//  meas_valid      in   1       Q meter result strobe
//  meas_data       in   WIDTH   Q meter result
//  busy            out  1       high in every state except IDLE
//  done            out  1       1-cycle pulse on search end (not on abort)
//  converged       out  1       status of last search, held until next start
//  timeout_err     out  1       status of last search, held until next start
//  iter_count      out  $clog2(MAX_ITER+1)  measurements taken in current/last search
//  final_i_ref     out  WIDTH   dac_code at search end, held until next done
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE. One clock; reset synchronous, active-high.
//  - States: IDLE, INIT, WAIT_CORE, LOAD, SETTLE, MEAS, EVAL, STEP, DONE.
//  - IDLE: start -> INIT; latch desired_q; clear converged, timeout_err, iter_count.
//  - INIT: core_rst=1 one cycle -> WAIT_CORE.
//  - WAIT_CORE: CORE_LAT cycles -> LOAD. STEP also enters WAIT_CORE.
//  - LOAD: dac_code<=core_i_ref, dac_load=1 one cycle -> SETTLE.
//  - SETTLE: counts SETTLE_CYCLES -> MEAS; meas_req rises first MEAS cycle.
//  - MEAS: meas_req high; meas_valid -> capture meas_data into core_measured_q, iter_count+1,
//    meas_req low next cycle -> EVAL. meas_valid outside MEAS ignored. No meas_valid within
//    TIMEOUT_CYCLES -> timeout_err=1, DONE.
//  - EVAL: err = WIDTH+1-bit signed (meas - desired), |err| compared unsigned.
//    |err|<=TOL -> converged=1, DONE; else iter_count==MAX_ITER -> DONE (converged=0);
//    else STEP. Convergence wins over iteration limit on same EVAL.
//  - STEP: core_ready=1 one cycle -> WAIT_CORE.
//  - DONE: done=1, final_i_ref<=dac_code, -> IDLE.
//  - abort: next state IDLE, meas_req/core_ready/dac_load drop, status unchanged, no done;
//    abort has priority over start in same cycle.
//  - start while busy ignored. dac_code holds last value in IDLE.
//  - Latency start->first dac_load = 2+CORE_LAT cycles.
// CONFIGURATION
//  MEAS_AVG_EN defined: each iteration takes 4 measurements (4 meas_req/meas_valid handshakes,
//   no re-settle between); core_measured_q = (sum of 4, WIDTH+2 bits)>>2, truncated; iter_count
//   counts iterations, not samples; timeout applies per handshake.
//  Undefined: one measurement per iteration as above.
// TESTING
//  1. rst, desired=512, meter returns 512 on first req -> done after 1 iter, converged=1, iter_count=1.
//  2. Meter model Q=i_ref, desired=300 -> converged=1, final_i_ref in 299..301, iter_count<=11.
//  3. Meter returns 0 forever, MAX_ITER=12 -> done, converged=0, iter_count=12, timeout_err=0.
//  4. meas_valid never asserted -> timeout_err=1 at TIMEOUT_CYCLES after meas_req, done pulse.
//  5. abort high in SETTLE -> IDLE next cycle, no done, meas_req never rises; new start restarts clean.
//  6. start during busy and stray meas_valid in SETTLE -> both ignored, result same as test 2.

Source files
------------

// File: rtl/bisection_sequencer.sv
// Bias-current search sequencer: steps the bisection core, loads the DAC, settles, measures Q and evaluates.
// Define MEAS_AVG_EN to average four Q measurements per iteration; the default build takes one.
module bisection_sequencer #(
  parameter int WIDTH          = 10,
  parameter int TOL            = 1,
  parameter int MAX_ITER       = 12,
  parameter int SETTLE_CYCLES  = 16,
  parameter int CORE_LAT       = 2,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int ITW           = $clog2(MAX_ITER + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] desired_q,
  input  logic [WIDTH-1:0] core_i_ref,
  output logic             core_rst,
  output logic             core_ready,
  output logic [WIDTH-1:0] core_measured_q,
  output logic [WIDTH-1:0] dac_code,
  output logic             dac_load,
  output logic             meas_req,
  input  logic             meas_valid,
  input  logic [WIDTH-1:0] meas_data,
  output logic             busy,
  output logic             done,
  output logic             converged,
  output logic             timeout_err,
  output logic [ITW-1:0]   iter_count,
  output logic [WIDTH-1:0] final_i_ref
);

  localparam int CNT_MAX =
    (TIMEOUT_CYCLES > SETTLE_CYCLES)
      ? ((TIMEOUT_CYCLES > CORE_LAT) ? TIMEOUT_CYCLES : CORE_LAT)
      : ((SETTLE_CYCLES > CORE_LAT) ? SETTLE_CYCLES : CORE_LAT);
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]  LAT_LAST    = CW'(CORE_LAT - 1);
  localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]  TMO_LAST    = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [ITW-1:0] ITER_MAX    = ITW'(MAX_ITER);
  localparam logic [WIDTH:0] TOL_W       = (WIDTH + 1)'(TOL);

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    WAIT_CORE,
    LOAD,
    SETTLE,
    MEAS,
    EVAL,
    STEP,
    DONE
  } state_t;

  state_t state, next_state;

  logic [CW-1:0]           cnt;
  logic [WIDTH-1:0]        desired_r;
  logic                    meas_last;
  logic [WIDTH-1:0]        new_q;
  logic signed [WIDTH:0]   err;
  logic [WIDTH:0]          abs_err;
  logic                    within_tol;

  // Error is formed one bit wider so that meas < desired stays representable.
  assign err        = $signed({1'b0, core_measured_q}) - $signed({1'b0, desired_r});
  assign abs_err    = err[WIDTH] ? $unsigned(-err) : $unsigned(err);
  assign within_tol = (abs_err <= TOL_W);

`ifdef MEAS_AVG_EN
  logic [1:0]       samp;
  logic [WIDTH+1:0] sum;
  logic [WIDTH+1:0] sum_total;

  assign sum_total = sum + {2'b00, meas_data};
  assign meas_last = (samp == 2'd3);
  assign new_q     = sum_total[WIDTH+1:2];

  // meas_req stays high across the four handshakes; each meas_valid strobe completes one sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp <= '0;
      sum  <= '0;
    end else if (state != MEAS || abort) begin
      samp <= '0;
      sum  <= '0;
    end else if (meas_valid) begin
      samp <= samp + 2'd1;
      sum  <= meas_last ? '0 : sum_total;
    end
  end
`else
  assign meas_last = 1'b1;
  assign new_q     = meas_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:      if (start) next_state = INIT;
        INIT:      next_state = WAIT_CORE;
        WAIT_CORE: if (cnt == LAT_LAST) next_state = LOAD;
        LOAD:      next_state = SETTLE;
        SETTLE:    if (cnt == SETTLE_LAST) next_state = MEAS;
        MEAS: begin
          if (meas_valid) begin
            if (meas_last) next_state = EVAL;
          end else if (cnt == TMO_LAST) begin
            next_state = DONE;
          end
        end
        // Convergence is tested first so it wins over the iteration limit.
        EVAL: begin
          if (within_tol)                 next_state = DONE;
          else if (iter_count == ITER_MAX) next_state = DONE;
          else                            next_state = STEP;
        end
        STEP:    next_state = WAIT_CORE;
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    core_rst   = 1'b0;
    core_ready = 1'b0;
    dac_load   = 1'b0;
    meas_req   = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    if (!abort) begin
      case (state)
        INIT:    core_rst   = 1'b1;
        LOAD:    dac_load   = 1'b1;
        MEAS:    meas_req   = 1'b1;
        STEP:    core_ready = 1'b1;
        DONE:    done       = 1'b1;
        default: ;
      endcase
    end
  end

  // Shared phase counter restarts on every state change and on each accepted measurement.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == IDLE || next_state != state || (state == MEAS && meas_valid)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // dac_code is captured on the edge entering LOAD so the code is stable while dac_load is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      desired_r       <= '0;
      dac_code        <= '0;
      core_measured_q <= '0;
      iter_count      <= '0;
      converged       <= 1'b0;
      timeout_err     <= 1'b0;
      final_i_ref     <= '0;
    end else if (!abort) begin
      case (state)
        IDLE: begin
          if (start) begin
            desired_r   <= desired_q;
            converged   <= 1'b0;
            timeout_err <= 1'b0;
            iter_count  <= '0;
          end
        end
        WAIT_CORE: begin
          if (cnt == LAT_LAST) dac_code <= core_i_ref;
        end
        MEAS: begin
          if (meas_valid) begin
            if (meas_last) begin
              core_measured_q <= new_q;
              iter_count      <= iter_count + 1'b1;
            end
          end else if (cnt == TMO_LAST) begin
            timeout_err <= 1'b1;
          end
        end
        EVAL: begin
          if (within_tol) converged <= 1'b1;
        end
        DONE: begin
          final_i_ref <= dac_code;
        end
        default: ;
      endcase
    end
  end

endmodule
